snow64_alu_line_sequencer: RTL



---
 rtl/snow64_alu_line_sequencer_pkg.sv | 73 +++++++
 rtl/snow64_alu_line_sequencer_alu.sv | 46 ++++
 rtl/snow64_alu_line_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/snow64_alu_line_sequencer_pkg.sv
// Shared types for the Snow64 line sequencer and its 64-bit SIMD ALU.
// Holds the line/beat geometry, ALU operation and lane-size encodings,
// the sequencer FSM state type, and the ALU/sequencer port structs.
package snow64_alu_line_sequencer_pkg;

    localparam int unsigned MSB_POS__SNOW64_LINE = 255;
    localparam int unsigned NUM_BEATS            = 4;
    localparam int unsigned MSB_POS__ALU_DATA    = 63;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4
    } alu_oper_e;

    typedef enum logic [1:0] {
        TypSz8  = 2'd0,
        TypSz16 = 2'd1,
        TypSz32 = 2'd2,
        TypSz64 = 2'd3
    } type_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } st_alu_line_seq_e;

    typedef struct packed {
        alu_oper_e                    oper;
        type_size_e                   type_size;
        logic [MSB_POS__ALU_DATA:0]   a;
        logic [MSB_POS__ALU_DATA:0]   b;
        logic                         carry;
    } port_in_alu_t;

    typedef struct packed {
        logic [MSB_POS__ALU_DATA:0]   data;
        logic                         carry;
    } port_out_alu_t;

    typedef struct packed {
        logic                            req_valid;
        alu_oper_e                       oper;
        type_size_e                      type_size;
        logic [MSB_POS__SNOW64_LINE:0]   a;
        logic [MSB_POS__SNOW64_LINE:0]   b;
        logic                            rsp_ready;
    } port_in_alu_line_seq_t;

    typedef struct packed {
        logic                            req_ready;
        logic                            rsp_valid;
        logic [MSB_POS__SNOW64_LINE:0]   rsp_data;
    } port_out_alu_line_seq_t;

    // True when byte idx is the least-significant byte of a lane.
    function automatic logic lane_start(input type_size_e ts, input logic [2:0] idx);
        logic r;
        r = 1'b0;
        unique case (ts)
            TypSz8:  r = 1'b1;
            TypSz16: r = (idx[0] == 1'b0);
            TypSz32: r = (idx[1:0] == 2'b00);
            TypSz64: r = (idx == 3'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snow64_alu_line_sequencer_alu.sv
// Snow64Alu: combinational 64-bit SIMD ALU.
// Ports:
//   in_i  - oper, lane size, a, b, carry-in (carry enters byte 0 only)
//   out_o - result data and carry-out of the top byte
// Add/sub run a byte-wide carry chain that is cut at every lane start.
// Unknown opers produce zeros.
module snow64_alu_line_sequencer_alu
    import snow64_alu_line_sequencer_pkg::*;
(
    input  port_in_alu_t  in_i,
    output port_out_alu_t out_o
);

    logic [63:0] b_eff;
    logic [63:0] sum_data;
    logic [8:0]  sum;
    logic        carry;

    always_comb begin
        out_o    = '0;
        sum_data = '0;
        sum      = '0;
        b_eff    = (in_i.oper == OpSub) ? ~in_i.b : in_i.b;
        carry    = in_i.carry;
        for (int i = 0; i < 8; i++) begin
            // Sub is a + ~b + 1 per lane; add only takes the external carry at byte 0.
            if (lane_start(in_i.type_size, 3'(i))) begin
                carry = (in_i.oper == OpSub) ? 1'b1 : ((i == 0) ? in_i.carry : 1'b0);
            end
            sum = {1'b0, in_i.a[8*i +: 8]} + {1'b0, b_eff[8*i +: 8]} + {8'b0, carry};
            sum_data[8*i +: 8] = sum[7:0];
            carry = sum[8];
        end
        case (in_i.oper)
            OpAdd, OpSub: begin
                out_o.data  = sum_data;
                out_o.carry = carry;
            end
            OpAnd:   out_o.data = in_i.a & in_i.b;
            OpOr:    out_o.data = in_i.a | in_i.b;
            OpXor:   out_o.data = in_i.a ^ in_i.b;
            default: out_o = '0;
        endcase
    end

endmodule

// File: rtl/snow64_alu_line_sequencer.sv
// Line sequencer: runs a 256-bit line through the 64-bit SIMD ALU as four
// consecutive beats, registering each beat result, then offers the full line.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   in_req_valid / out_req_ready     - request handshake
//   in_req_oper, in_req_type_size    - ALU operation and lane size
//   in_req_a, in_req_b               - line operands
//   out_rsp_valid / in_rsp_ready     - response handshake
//   out_rsp_data                     - result line
module snow64_alu_line_sequencer
    import snow64_alu_line_sequencer_pkg::*;
#(
    parameter int unsigned MSB_POS__LINE = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_req_valid,
    output logic                     out_req_ready,
    input  logic [3:0]               in_req_oper,
    input  logic [1:0]               in_req_type_size,
    input  logic [MSB_POS__LINE:0]   in_req_a,
    input  logic [MSB_POS__LINE:0]   in_req_b,
    output logic                     out_rsp_valid,
    input  logic                     in_rsp_ready,
    output logic [MSB_POS__LINE:0]   out_rsp_data
);

    localparam int unsigned NumBeats = (MSB_POS__LINE + 1) / 64;
    localparam logic [1:0]  LastBeat = 2'(NumBeats - 1);

    st_alu_line_seq_e       state_q, state_d;
    logic [1:0]             beat_q;
    alu_oper_e              oper_q;
    type_size_e             type_size_q;
    logic [MSB_POS__LINE:0] a_q, b_q, result_q;
    logic                   accept;
    port_in_alu_t           alu_in;
    port_out_alu_t          alu_out;
    logic                   unused_alu_carry;

    assign accept = in_req_valid & out_req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRun;
            StRun:  if (beat_q == LastBeat) state_d = StDone;
            StDone: if (in_rsp_ready) state_d = accept ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs. A done line can be replaced by a new request in the cycle it is taken.
    always_comb begin
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: out_req_ready = rst_n;
            StRun:  out_req_ready = 1'b0;
            StDone: begin
                out_rsp_valid = 1'b1;
                out_req_ready = rst_n & in_rsp_ready;
            end
            default: out_req_ready = 1'b0;
        endcase
    end

    assign out_rsp_data = result_q;

    // Operand capture and beat accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q      <= '0;
            oper_q      <= OpAdd;
            type_size_q <= TypSz8;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
        end else if (accept) begin
            beat_q      <= '0;
            oper_q      <= alu_oper_e'(in_req_oper);
            type_size_q <= type_size_e'(in_req_type_size);
            a_q         <= in_req_a;
            b_q         <= in_req_b;
        end else if (state_q == StRun) begin
            result_q[{beat_q, 6'b0} +: 64] <= alu_out.data;
            beat_q                         <= beat_q + 2'd1;
        end
    end

    // Lanes never cross a beat, so no carry is chained between beats.
    always_comb begin
        alu_in           = '0;
        alu_in.oper      = oper_q;
        alu_in.type_size = type_size_q;
        alu_in.a         = a_q[{beat_q, 6'b0} +: 64];
        alu_in.b         = b_q[{beat_q, 6'b0} +: 64];
        alu_in.carry     = 1'b0;
    end

    snow64_alu_line_sequencer_alu u_alu (
        .in_i  (alu_in),
        .out_o (alu_out)
    );

    assign unused_alu_carry = alu_out.carry;

endmodule
